student_ram8: RTL

STUDENT_RAM8 -- requirements
Module: student_ram8

---
 rtl/student_ram8.sv | 118 +++++++++++
 1 files changed

// File: rtl/student_ram8.sv
// Eight-word register file assembled structurally from single-bit flip-flop cells.
// The write-enable demux, the read mux and the bit-cell select are all built from AND/OR/NOT gates.

module student_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic in,
    output logic out
);
    logic next;

    // 2:1 select from gates: take the new data when load is high, otherwise keep the stored bit
    assign next = (load & in) | (~load & out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= 1'b0;
        else        out <= next;
    end
endmodule

module student_register16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        student_bit u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .load (load),
            .in   (in[b]),
            .out  (out[b])
        );
    end
endmodule

module student_dmux8 (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);
    // The enable is ANDed into every term, so an unknown sel with in=0 still gives all zeros
    for (genvar i = 0; i < 8; i++) begin : g_dec
        localparam logic [2:0] IDX = 3'(i);
        assign out[i] = in
                      & (IDX[2] ? sel[2] : ~sel[2])
                      & (IDX[1] ? sel[1] : ~sel[1])
                      & (IDX[0] ? sel[0] : ~sel[0]);
    end
endmodule

module student_mux8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0][WIDTH-1:0] in,
    input  logic [2:0]            sel,
    output logic [WIDTH-1:0]      out
);
    logic [7:0] dec;

    for (genvar i = 0; i < 8; i++) begin : g_dec
        localparam logic [2:0] IDX = 3'(i);
        assign dec[i] = (IDX[2] ? sel[2] : ~sel[2])
                      & (IDX[1] ? sel[1] : ~sel[1])
                      & (IDX[0] ? sel[0] : ~sel[0]);
    end

    // AND-OR tree: each word is gated by its one-hot select and all of them are ORed together
    always_comb begin
        out = '0;
        for (int i = 0; i < 8; i++) begin
            out = out | (in[i] & {WIDTH{dec[i]}});
        end
    end
endmodule

module student_ram8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);
    localparam int unsigned DEPTH = 8;

    logic [DEPTH-1:0]            word_load;
    logic [DEPTH-1:0][WIDTH-1:0] words;

    student_dmux8 u_dmux (
        .in (load),
        .sel(address),
        .out(word_load)
    );

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        student_register16 #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .rst_n(rst_n),
            .load (word_load[w]),
            .in   (in),
            .out  (words[w])
        );
    end

    student_mux8 #(.WIDTH(WIDTH)) u_mux (
        .in (words),
        .sel(address),
        .out(out)
    );
endmodule
